// File: rtl/mem_responder.sv
// mem_responder: word-RAM / memory-mapped I/O responder for the MiniSRC memory port.
// A request accepted in IDLE is committed after WAIT_STATES extra cycles.
// Completion is signalled by a one-cycle oAck, which comes together with oFault
// and oIO_OutValid when they apply.
module mem_responder #(
  parameter int          ADDR_BITS    = 9,
  parameter int          WAIT_STATES  = 1,
  parameter logic [31:0] IO_IN_ADDR   = 32'hFFFF_FFF0,
  parameter logic [31:0] IO_STAT_ADDR = 32'hFFFF_FFF4,
  parameter logic [31:0] IO_OUT_ADDR  = 32'hFFFF_FFF8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oAck,
  output logic        oBusy,
  output logic        oFault,
  input  logic [31:0] iIO_In,
  input  logic        iIO_InStrobe,
  output logic [31:0] oIO_Out,
  output logic        oIO_OutValid
);

  localparam logic [3:0] WS_C  = 4'(WAIT_STATES);
  localparam int         DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  cnt_r;
  logic        write_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] data_r;
  logic        ack_r;
  logic        busy_r;
  logic        fault_r;
  logic [31:0] io_out_r;
  logic        io_out_valid_r;
  logic [31:0] in_reg_r;
  logic        in_valid_r;
  logic [31:0] mem_r [DEPTH];

  logic                 accept_s;
  logic                 commit_s;
  logic                 acc_write_s;
  logic [31:0]          acc_addr_s;
  logic [31:0]          acc_wdata_s;
  logic                 is_ram_s;
  logic                 is_in_s;
  logic                 is_stat_s;
  logic                 is_out_s;
  logic [ADDR_BITS-1:0] ram_idx_s;
  logic [31:0]          rd_s;
  logic                 fault_s;

  // Next-state logic for the IDLE/WAIT/ACK access sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (iReq) begin
          if (WS_C == 4'd0) begin
            state_next_s = ST_ACK;
          end else begin
            state_next_s = ST_WAIT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_next_s = ST_ACK;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_ACK:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Select the access operands: with zero wait states the access commits on the
  // accepting edge, so it must use the live inputs rather than the latched copy.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && iReq;
    commit_s    = 1'b0;
    acc_write_s = write_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    if (state_r == ST_WAIT) begin
      commit_s = (cnt_r == 4'd1);
    end else begin
      commit_s    = accept_s && (WS_C == 4'd0);
      acc_write_s = iWrite;
      acc_addr_s  = iAddr;
      acc_wdata_s = iData;
    end
  end

  // Address decode, read-data mux and fault classification for the committing access.
  always_comb begin
    is_ram_s  = ((acc_addr_s >> ADDR_BITS) == 32'd0);
    is_in_s   = (acc_addr_s == IO_IN_ADDR);
    is_stat_s = (acc_addr_s == IO_STAT_ADDR);
    is_out_s  = (acc_addr_s == IO_OUT_ADDR);
    ram_idx_s = acc_addr_s[ADDR_BITS-1:0];
    rd_s      = 32'h0;
    fault_s   = 1'b0;
    if (is_ram_s) begin
      rd_s = mem_r[ram_idx_s];
    end else if (is_in_s) begin
      rd_s    = in_reg_r;
      fault_s = acc_write_s;
    end else if (is_stat_s) begin
      rd_s    = {31'd0, in_valid_r};
      fault_s = acc_write_s;
    end else if (is_out_s) begin
      rd_s = io_out_r;
    end else begin
      rd_s    = 32'h0;
      fault_s = 1'b1;
    end
  end

  // Sequencer state, operand latch, registered outputs and I/O registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      write_r        <= 1'b0;
      addr_r         <= 32'h0;
      wdata_r        <= 32'h0;
      data_r         <= 32'h0;
      ack_r          <= 1'b0;
      busy_r         <= 1'b0;
      fault_r        <= 1'b0;
      io_out_r       <= 32'h0;
      io_out_valid_r <= 1'b0;
      in_reg_r       <= 32'h0;
      in_valid_r     <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      busy_r         <= (state_next_s != ST_IDLE);
      ack_r          <= commit_s;
      fault_r        <= commit_s && fault_s;
      io_out_valid_r <= commit_s && acc_write_s && is_out_s;
      if (accept_s) begin
        write_r <= iWrite;
        addr_r  <= iAddr;
        wdata_r <= iData;
        cnt_r   <= WS_C;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (commit_s && !acc_write_s) begin
        data_r <= rd_s;
      end
      if (commit_s && acc_write_s && is_out_s) begin
        io_out_r <= acc_wdata_s;
      end
      // A strobe on the same edge as an input-register read wins the valid flag.
      if (iIO_InStrobe) begin
        in_reg_r   <= iIO_In;
        in_valid_r <= 1'b1;
      end else if (commit_s && !acc_write_s && is_in_s) begin
        in_valid_r <= 1'b0;
      end
    end
  end

  // RAM write port; contents survive reset, but a reset edge suppresses the write.
  always_ff @(posedge iClk) begin
    if (!iRst && commit_s && acc_write_s && is_ram_s) begin
      mem_r[ram_idx_s] <= acc_wdata_s;
    end
  end

  assign oData        = data_r;
  assign oAck         = ack_r;
  assign oBusy        = busy_r;
  assign oFault       = fault_r;
  assign oIO_Out      = io_out_r;
  assign oIO_OutValid = io_out_valid_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (WAIT_STATES 1, 0, 3) driven by directed and
// random accesses. Each result is compared with a memory/register model kept in arrays.
module tb_mem_responder;

  localparam int          NI     = 3;
  localparam logic [31:0] A_IN   = 32'hFFFF_FFF0;
  localparam logic [31:0] A_STAT = 32'hFFFF_FFF4;
  localparam logic [31:0] A_OUT  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst    [NI];
  logic        req    [NI];
  logic        wr     [NI];
  logic [31:0] addr   [NI];
  logic [31:0] wdata  [NI];
  logic [31:0] rdata  [NI];
  logic        ack    [NI];
  logic        busy   [NI];
  logic        fault  [NI];
  logic [31:0] io_in  [NI];
  logic        strobe [NI];
  logic [31:0] io_out [NI];
  logic        ov     [NI];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state, one copy per instance.
  logic [31:0] m_mem      [NI][512];
  bit          m_known    [NI][512];
  logic [31:0] m_io_out   [NI];
  logic [31:0] m_in_reg   [NI];
  bit          m_in_valid [NI];
  logic [31:0] m_last     [NI];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(
      .ADDR_BITS  (9),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .iClk        (clk),
      .iRst        (rst[g]),
      .iReq        (req[g]),
      .iWrite      (wr[g]),
      .iAddr       (addr[g]),
      .iData       (wdata[g]),
      .oData       (rdata[g]),
      .oAck        (ack[g]),
      .oBusy       (busy[g]),
      .oFault      (fault[g]),
      .iIO_In      (io_in[g]),
      .iIO_InStrobe(strobe[g]),
      .oIO_Out     (io_out[g]),
      .oIO_OutValid(ov[g])
    );
  end

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_io_out[i]   = 32'h0;
    m_in_reg[i]   = 32'h0;
    m_in_valid[i] = 1'b0;
    m_last[i]     = 32'h0;
  endtask

  task automatic strobe_in(input int i, input logic [31:0] v);
    @(negedge clk);
    strobe[i] = 1'b1;
    io_in[i]  = v;
    @(posedge clk);
    @(negedge clk);
    strobe[i]     = 1'b0;
    io_in[i]      = $urandom;
    m_in_reg[i]   = v;
    m_in_valid[i] = 1'b1;
  endtask

  // One complete access. stb = 1 strobes stb_val on the accepting edge; it is used
  // only on the zero-wait instance, where that edge is also the commit edge.
  task automatic do_access(input int i, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input bit stb, input logic [31:0] stb_val);
    logic [31:0] exp_d;
    bit          exp_f;
    bit          exp_ov;
    int          k;
    exp_d  = m_last[i];
    exp_f  = 1'b0;
    exp_ov = 1'b0;
    if (a < 32'd512) begin
      if (!w) exp_d = m_mem[i][a[8:0]];
    end else if (a == A_IN) begin
      if (w) exp_f = 1'b1; else exp_d = m_in_reg[i];
    end else if (a == A_STAT) begin
      if (w) exp_f = 1'b1; else exp_d = {31'd0, m_in_valid[i]};
    end else if (a == A_OUT) begin
      if (w) exp_ov = 1'b1; else exp_d = m_io_out[i];
    end else begin
      exp_f = 1'b1;
      if (!w) exp_d = 32'h0;
    end
    if (w && a < 32'd512) begin
      m_mem[i][a[8:0]]   = d;
      m_known[i][a[8:0]] = 1'b1;
    end
    if (w && a == A_OUT) m_io_out[i] = d;
    if (!w && a == A_IN) m_in_valid[i] = 1'b0;
    if (stb) begin
      m_in_reg[i]   = stb_val;
      m_in_valid[i] = 1'b1;
    end
    if (!w) m_last[i] = exp_d;

    @(negedge clk);
    req[i]   = 1'b1;
    wr[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    if (stb) begin
      strobe[i] = 1'b1;
      io_in[i]  = stb_val;
    end
    @(posedge clk);
    @(negedge clk);
    req[i]    = 1'b0;
    strobe[i] = 1'b0;
    wr[i]     = 1'($urandom);
    addr[i]   = $urandom;
    wdata[i]  = $urandom;
    if (ws_of(i) > 0) check("busy_wait", 32'(busy[i]), 32'd1);
    k = 1;
    while (!ack[i] && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("ack_latency", 32'(k), 32'(ws_of(i) + 1));
    check("busy_ack", 32'(busy[i]), 32'd1);
    check("fault", 32'(fault[i]), 32'(exp_f));
    check("out_valid", 32'(ov[i]), 32'(exp_ov));
    check(w ? "rdata_hold" : "rdata", rdata[i], exp_d);
    check("io_out", io_out[i], m_io_out[i]);
    @(posedge clk);
    @(negedge clk);
    check("ack_one_cycle", 32'(ack[i]), 32'd0);
    check("busy_after", 32'(busy[i]), 32'd0);
    check("fault_one_cycle", 32'(fault[i]), 32'd0);
  endtask

  function automatic logic [31:0] pick_ram();
    if ($urandom_range(0, 3) == 0) return 32'd511;
    return 32'($urandom_range(0, 15));
  endfunction

  initial begin
    int          acks;
    int          ea;
    int          r;
    bit          w;
    logic [31:0] a;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'h0;
      wdata[i] = 32'h0; io_in[i] = 32'h0; strobe[i] = 1'b0;
      model_reset(i);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0;
      check("rst_data", rdata[i], 32'h0);
      check("rst_ack", 32'(ack[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_fault", 32'(fault[i]), 32'd0);
      check("rst_io_out", io_out[i], 32'h0);
      check("rst_out_valid", 32'(ov[i]), 32'd0);
    end

    // RAM write/read with one wait state.
    do_access(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'h0);
    do_access(0, 1'b0, 32'd5, 32'h0, 1'b0, 32'h0);

    // Output port, input port and status register.
    do_access(0, 1'b1, A_OUT, 32'h55, 1'b0, 32'h0);
    do_access(0, 1'b0, A_OUT, 32'h0, 1'b0, 32'h0);
    strobe_in(0, 32'h1234);
    do_access(0, 1'b0, A_STAT, 32'h0, 1'b0, 32'h0);
    do_access(0, 1'b0, A_IN, 32'h0, 1'b0, 32'h0);
    do_access(0, 1'b0, A_STAT, 32'h0, 1'b0, 32'h0);

    // Faults: unmapped read, write to the input register (leaves it unchanged).
    do_access(0, 1'b0, 32'd512, 32'h0, 1'b0, 32'h0);
    do_access(0, 1'b1, A_IN, 32'hCAFE_F00D, 1'b0, 32'h0);
    do_access(0, 1'b0, A_IN, 32'h0, 1'b0, 32'h0);

    // Zero wait states with iReq held high for 6 cycles: reads alternate 0,1,0.
    do_access(1, 1'b1, 32'd0, 32'hA0A0_0000, 1'b0, 32'h0);
    do_access(1, 1'b1, 32'd1, 32'hB1B1_0001, 1'b0, 32'h0);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'd0;
    acks = 0;
    ea   = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_ack_pattern", 32'(ack[1]), 32'((c % 2) == 0));
      if (ack[1]) begin
        acks++;
        check("hold_data", rdata[1], m_mem[1][ea]);
        ea      = 1 - ea;
        addr[1] = 32'(ea);
      end
    end
    req[1] = 1'b0;
    check("hold_ack_count", 32'(acks), 32'd3);
    m_last[1] = m_mem[1][0];

    // Strobe on the same edge as a committing input-register read.
    strobe_in(1, 32'h0000_AAAA);
    do_access(1, 1'b0, A_IN, 32'h0, 1'b1, 32'h0000_BBBB);
    do_access(1, 1'b0, A_STAT, 32'h0, 1'b0, 32'h0);
    do_access(1, 1'b0, A_IN, 32'h0, 1'b0, 32'h0);

    // Reset during WAIT of a write (three wait states).
    do_access(2, 1'b1, 32'd7, 32'h0000_0077, 1'b0, 32'h0);
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'd7; wdata[2] = 32'h0000_0099;
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b0;
    model_reset(2);
    check("rst_mid_ack", 32'(ack[2]), 32'd0);
    check("rst_mid_busy", 32'(busy[2]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_no_ack", 32'(ack[2]), 32'd0);
    end
    do_access(2, 1'b0, 32'd7, 32'h0, 1'b0, 32'h0);

    // Random accesses on every instance.
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 40; n++) begin
        r = int'($urandom_range(0, 9));
        w = ($urandom_range(0, 2) == 0);
        case (r)
          0, 1, 2: do_access(i, 1'b1, pick_ram(), $urandom, 1'b0, 32'h0);
          3, 4: begin
            a = pick_ram();
            do_access(i, !m_known[i][a[8:0]], a, $urandom, 1'b0, 32'h0);
          end
          5: do_access(i, w, A_IN, $urandom, 1'b0, 32'h0);
          6: do_access(i, w, A_STAT, $urandom, 1'b0, 32'h0);
          7: do_access(i, 1'($urandom), A_OUT, $urandom, 1'b0, 32'h0);
          8: begin
            if ($urandom_range(0, 1) == 0) a = 32'd512 + 32'($urandom_range(0, 1000));
            else a = 32'hFFFF_FFFC;
            do_access(i, 1'($urandom), a, $urandom, 1'b0, 32'h0);
          end
          default: begin
            if (ws_of(i) == 0 && $urandom_range(0, 1) == 0)
              do_access(i, 1'b0, A_IN, 32'h0, 1'b1, $urandom);
            else
              strobe_in(i, $urandom);
          end
        endcase
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
